// File: rtl/video_pkg.sv
// video_pkg: shared state encoding, address composition and attribute select for the video fetch scheduler.
package video_pkg;
  typedef enum logic [3:0] {IDLE, NT_A, NT_D, AT_A, AT_D, PL_A, PL_D, PH_A, PH_D, HA, HD} fetch_state_t;
  localparam logic [13:0] NT_BASE = 14'h2000;
  localparam logic [9:0] AT_OFFSET = 10'h3C0;
  function automatic logic [13:0] nt_addr(input logic [13:0] base, input logic [1:0] nt,
                                          input logic [4:0] ty, input logic [4:0] tx);
    return base | {2'b0, nt, 10'b0} | {4'b0, ty, 5'b0} | {9'b0, tx};
  endfunction
  function automatic logic [13:0] at_addr(input logic [13:0] base, input logic [9:0] off,
                                          input logic [1:0] nt, input logic [4:0] ty, input logic [4:0] tx);
    return base | {2'b0, nt, 10'b0} | {4'b0, off} | {8'b0, ty[4:2], 3'b0} | {11'b0, tx[4:2]};
  endfunction
  function automatic logic [13:0] pt_addr(input logic pt, input logic [7:0] idx,
                                          input logic hi, input logic [2:0] fy);
    return {1'b0, pt, idx, hi, fy};
  endfunction
  function automatic logic [1:0] attr_select(input logic [7:0] b, input logic y1, input logic x1);
    logic [7:0] s;
    s = b >> {y1, x1, 1'b0};
    return s[1:0];
  endfunction
endpackage

// File: rtl/video_fetch_sched.sv
// video_fetch_sched: shares the cart bus between the 8-dot background tile fetch and host accesses.
module video_fetch_sched import video_pkg::*; #(
  parameter logic [13:0] G_nt_base = NT_BASE,
  parameter logic [9:0] G_at_offset = AT_OFFSET
) (
  input  logic        I_clock,
  input  logic        I_reset,
  input  logic        I_dot_ce,
  input  logic        I_fetch_en,
  input  logic        I_line_start,
  input  logic [4:0]  I_scroll_tx,
  input  logic [4:0]  I_tile_y,
  input  logic [2:0]  I_fine_y,
  input  logic [1:0]  I_nt_sel,
  input  logic        I_pt_sel,
  input  logic        I_host_req,
  input  logic [13:0] I_host_addr,
  input  logic        I_host_wren,
  input  logic [7:0]  I_host_data,
  output logic        O_host_ack,
  output logic [7:0]  O_host_rdata,
  output logic [13:0] O_cart_addr,
  output logic        O_cart_wren,
  output logic [7:0]  O_cart_data,
  input  logic [7:0]  I_cart_data,
  output logic [7:0]  O_tile_index,
  output logic [1:0]  O_tile_attr,
  output logic [7:0]  O_pat_lo,
  output logic [7:0]  O_pat_hi,
  output logic        O_tile_valid
);
  fetch_state_t r_state, w_next, w_pick;
  logic [4:0] r_tile_x;
  logic [1:0] r_nt, r_attr, r_tile_attr;
  logic [7:0] r_idx, r_lo, r_tile_index, r_pat_lo, r_pat_hi, r_host_rdata, r_host_data;
  logic [13:0] r_host_addr, w_addr;
  logic r_host_wren, r_tile_valid, r_host_ack, w_host;
  assign w_pick = I_fetch_en ? NT_A : I_host_req ? HA : IDLE;
  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE, PH_D: w_next = w_pick;
      NT_A: w_next = NT_D;
      NT_D: w_next = AT_A;
      AT_A: w_next = AT_D;
      AT_D: w_next = PL_A;
      PL_A: w_next = PL_D;
      PL_D: w_next = PH_A;
      PH_A: w_next = PH_D;
      HA:   w_next = HD;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    w_addr = 14'h0;
    case (r_state)
      NT_A, NT_D: w_addr = nt_addr(G_nt_base, r_nt, I_tile_y, r_tile_x);
      AT_A, AT_D: w_addr = at_addr(G_nt_base, G_at_offset, r_nt, I_tile_y, r_tile_x);
      PL_A, PL_D: w_addr = pt_addr(I_pt_sel, r_idx, 1'b0, I_fine_y);
      PH_A, PH_D: w_addr = pt_addr(I_pt_sel, r_idx, 1'b1, I_fine_y);
      HA, HD:     w_addr = r_host_addr;
      default:    w_addr = 14'h0;
    endcase
  end
  assign w_host = (r_state == HA) || (r_state == HD);
  assign O_cart_addr = w_addr;
  assign O_cart_wren = w_host & r_host_wren;
  assign O_cart_data = w_host ? r_host_data : 8'h0;
  always_ff @(posedge I_clock) begin
    if (I_reset) begin
      r_state <= IDLE;
      r_tile_x <= 5'd0;
      r_nt <= 2'd0;
      r_idx <= 8'h0;
      r_attr <= 2'd0;
      r_lo <= 8'h0;
      r_tile_index <= 8'h0;
      r_tile_attr <= 2'd0;
      r_pat_lo <= 8'h0;
      r_pat_hi <= 8'h0;
      r_tile_valid <= 1'b0;
      r_host_addr <= 14'h0;
      r_host_data <= 8'h0;
      r_host_wren <= 1'b0;
      r_host_rdata <= 8'h0;
      r_host_ack <= 1'b0;
    end else begin
      r_tile_valid <= 1'b0;
      r_host_ack <= 1'b0;
      if (I_dot_ce) begin
        r_state <= w_next;
        if (w_next == HA) begin
          r_host_addr <= I_host_addr;
          r_host_data <= I_host_data;
          r_host_wren <= I_host_wren;
        end
        if (r_state == NT_D) r_idx <= I_cart_data;
        if (r_state == AT_D) r_attr <= attr_select(I_cart_data, I_tile_y[1], r_tile_x[1]);
        if (r_state == PL_D) r_lo <= I_cart_data;
        // publish the whole tile at once so consumers never see a mix of old and new planes
        if (r_state == PH_D) begin
          r_tile_index <= r_idx;
          r_tile_attr <= r_attr;
          r_pat_lo <= r_lo;
          r_pat_hi <= I_cart_data;
          r_tile_valid <= 1'b1;
        end
        if (r_state == HD) begin
          r_host_rdata <= I_cart_data;
          r_host_ack <= 1'b1;
        end
        if (I_line_start) begin
          r_tile_x <= I_scroll_tx;
          r_nt <= I_nt_sel;
        end else if (r_state == PH_D) begin
          r_tile_x <= r_tile_x + 5'd1;
          if (&r_tile_x) r_nt[0] <= ~r_nt[0];
        end
      end
    end
  end
  assign O_tile_index = r_tile_index;
  assign O_tile_attr = r_tile_attr;
  assign O_pat_lo = r_pat_lo;
  assign O_pat_hi = r_pat_hi;
  assign O_tile_valid = r_tile_valid;
  assign O_host_rdata = r_host_rdata;
  assign O_host_ack = r_host_ack;
endmodule

// File: tb/tb_video_fetch_sched.sv
// tb_video_fetch_sched: directed vectors plus corner sequences against a small cart memory model.
module tb_video_fetch_sched;
  logic clk = 1'b0, rst = 1'b0, dot_ce = 1'b0, fe = 1'b0, ls = 1'b0, pt_sel = 1'b0;
  logic hreq = 1'b0, hwr = 1'b0;
  logic [4:0] scroll = '0, ty = '0;
  logic [2:0] fy = '0;
  logic [1:0] nt_sel = '0;
  logic [13:0] haddr = '0;
  logic [7:0] hdata = '0;
  logic ack, cwren, valid;
  logic [7:0] rdata, cdata, cdin, idx, lo, hi;
  logic [13:0] caddr;
  logic [1:0] attr;
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  video_fetch_sched dut (
    .I_clock(clk), .I_reset(rst), .I_dot_ce(dot_ce), .I_fetch_en(fe), .I_line_start(ls),
    .I_scroll_tx(scroll), .I_tile_y(ty), .I_fine_y(fy), .I_nt_sel(nt_sel), .I_pt_sel(pt_sel),
    .I_host_req(hreq), .I_host_addr(haddr), .I_host_wren(hwr), .I_host_data(hdata),
    .O_host_ack(ack), .O_host_rdata(rdata), .O_cart_addr(caddr), .O_cart_wren(cwren),
    .O_cart_data(cdata), .I_cart_data(cdin), .O_tile_index(idx), .O_tile_attr(attr),
    .O_pat_lo(lo), .O_pat_hi(hi), .O_tile_valid(valid)
  );
  function automatic logic [7:0] model(input logic [13:0] a);
    if (a[13:8] == 6'h3F) return a[7:0] ^ 8'h99;
    if (a[13] && a[9:6] == 4'hF) return 8'b11_10_01_00;
    if (a[13]) return 8'h41;
    return a[3] ? 8'h5A : 8'hA5;
  endfunction
  assign cdin = model(caddr);
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic tick;
    @(negedge clk);
    dot_ce = 1'b1;
    @(negedge clk);
    dot_ce = 1'b0;
  endtask
  task automatic tile_from_idle(input logic [4:0] sx, input logic [4:0] y, input logic [1:0] exp_attr);
    scroll = sx; ty = y; ls = 1'b1; fe = 1'b1;
    tick;
    ls = 1'b0; fe = 1'b0;
    repeat (7) tick;
    chk("tile early valid", valid, 0);
    tick;
    chk("tile valid", valid, 1);
    chk("tile attr", attr, exp_attr);
  endtask
  typedef struct {
    logic ls, fe, hreq, hwr;
    logic [13:0] addr;
    logic wren, valid, ack;
  } vec_t;
  vec_t vt[13];
  initial begin
    logic seen;
    vt[0]  = '{1, 1, 0, 0, 14'h20A3, 0, 0, 0};
    vt[1]  = '{0, 1, 0, 0, 14'h20A3, 0, 0, 0};
    vt[2]  = '{0, 1, 0, 0, 14'h23C8, 0, 0, 0};
    vt[3]  = '{0, 1, 0, 0, 14'h23C8, 0, 0, 0};
    vt[4]  = '{0, 1, 0, 0, 14'h1412, 0, 0, 0};
    vt[5]  = '{0, 1, 0, 0, 14'h1412, 0, 0, 0};
    vt[6]  = '{0, 1, 0, 0, 14'h141A, 0, 0, 0};
    vt[7]  = '{0, 0, 0, 0, 14'h141A, 0, 0, 0};
    vt[8]  = '{0, 0, 0, 0, 14'h0000, 0, 1, 0};
    vt[9]  = '{0, 0, 1, 1, 14'h3F00, 1, 0, 0};
    vt[10] = '{0, 0, 1, 1, 14'h3F00, 1, 0, 0};
    vt[11] = '{0, 0, 1, 1, 14'h0000, 0, 0, 1};
    vt[12] = '{0, 0, 0, 0, 14'h0000, 0, 0, 0};
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset addr", caddr, 0);
    chk("reset wren", cwren, 0);
    chk("reset valid", valid, 0);
    chk("reset ack", ack, 0);
    chk("reset index", idx, 0);
    chk("reset rdata", rdata, 0);
    scroll = 5'd3; ty = 5'd5; fy = 3'd2; nt_sel = 2'd0; pt_sel = 1'b1;
    haddr = 14'h3F00; hdata = 8'h2C;
    for (int i = 0; i < 13; i++) begin
      ls = vt[i].ls; fe = vt[i].fe; hreq = vt[i].hreq; hwr = vt[i].hwr;
      tick;
      chk($sformatf("vec%0d addr", i), caddr, vt[i].addr);
      chk($sformatf("vec%0d wren", i), cwren, vt[i].wren);
      chk($sformatf("vec%0d valid", i), valid, vt[i].valid);
      chk($sformatf("vec%0d ack", i), ack, vt[i].ack);
      if (vt[i].wren) chk($sformatf("vec%0d wdata", i), cdata, 8'h2C);
      if (i == 8) begin
        chk("tile1 index", idx, 8'h41);
        chk("tile1 attr", attr, 2'b01);
        chk("tile1 lo", lo, 8'hA5);
        chk("tile1 hi", hi, 8'h5A);
      end
    end
    ls = 1'b0; hwr = 1'b0;
    tile_from_idle(5'd2, 5'd0, 2'b01);
    tile_from_idle(5'd2, 5'd2, 2'b11);
    tile_from_idle(5'd0, 5'd2, 2'b10);
    // two back-to-back tiles across the X wrap
    scroll = 5'd31; ty = 5'd7; ls = 1'b1; fe = 1'b1;
    tick;
    ls = 1'b0;
    chk("wrap first nt", caddr, 14'h20FF);
    repeat (8) tick;
    chk("wrap second nt", caddr, 14'h24E0);
    chk("wrap valid", valid, 1);
    fe = 1'b0;
    repeat (8) tick;
    chk("wrap idle", caddr, 0);
    // host read queued behind an active fetch
    haddr = 14'h3F05; hwr = 1'b0; hreq = 1'b1; fe = 1'b1; ls = 1'b1; scroll = 5'd0; ty = 5'd1;
    tick;
    ls = 1'b0;
    chk("hrd fetch priority", caddr, 14'h2020);
    seen = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      fe = (i <= 8);
      tick;
      seen |= cwren | ack;
      if (i == 8 || i == 16) chk($sformatf("hrd valid t%0d", i), valid, 1);
    end
    chk("hrd no wren or ack in fetch", seen, 0);
    chk("hrd HA addr", caddr, 14'h3F05);
    tick;
    chk("hrd HD addr", caddr, 14'h3F05);
    chk("hrd HD wren", cwren, 0);
    tick;
    chk("hrd ack", ack, 1);
    chk("hrd rdata", rdata, 8'h9C);
    hreq = 1'b0;
    tick;
    chk("hrd ack pulse", ack, 0);
    // fetch_en rising mid host access lets the access finish first
    haddr = 14'h3F10; hreq = 1'b1;
    tick;
    fe = 1'b1;
    tick;
    chk("hfe HD addr", caddr, 14'h3F10);
    tick;
    chk("hfe ack", ack, 1);
    chk("hfe rdata", rdata, 8'h89);
    chk("hfe idle", caddr, 0);
    hreq = 1'b0; ls = 1'b1; scroll = 5'd0; ty = 5'd4;
    tick;
    ls = 1'b0; fe = 1'b0;
    chk("hfe fetch start", caddr, 14'h2080);
    repeat (8) tick;
    chk("hfe tile valid", valid, 1);
    // reset landing on the dot that would leave PL_D
    ls = 1'b1; fe = 1'b1; scroll = 5'd9; ty = 5'd3;
    tick;
    ls = 1'b0; fe = 1'b0;
    repeat (5) tick;
    chk("rst pl_d addr", caddr, 14'h1412);
    @(negedge clk);
    rst = 1'b1; dot_ce = 1'b1;
    @(negedge clk);
    rst = 1'b0; dot_ce = 1'b0;
    chk("rst pl addr", caddr, 0);
    chk("rst pl index", idx, 0);
    chk("rst pl attr", attr, 0);
    chk("rst pl lo", lo, 0);
    chk("rst pl hi", hi, 0);
    chk("rst pl valid", valid, 0);
    seen = 1'b0;
    repeat (8) begin
      tick;
      seen |= valid;
    end
    chk("rst pl no valid later", seen, 0);
    fe = 1'b1;
    tick;
    fe = 1'b0;
    chk("rst tile_x nt cleared", caddr, 14'h2060);
    repeat (8) tick;
    // reset landing on the dot that would leave HD
    haddr = 14'h3F00; hwr = 1'b1; hdata = 8'h77; hreq = 1'b1;
    tick;
    tick;
    chk("rst hd wren", cwren, 1);
    @(negedge clk);
    rst = 1'b1; dot_ce = 1'b1;
    @(negedge clk);
    rst = 1'b0; dot_ce = 1'b0; hreq = 1'b0;
    chk("rst hd ack", ack, 0);
    chk("rst hd wren off", cwren, 0);
    chk("rst hd addr", caddr, 0);
    chk("rst hd rdata", rdata, 0);
    tick;
    chk("rst hd no late ack", ack, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
